// File: rtl/async_fifo.sv
// Single-clock FIFO: DEPTH x WIDTH storage, registered read data,
// full/empty status and a one-cycle error pulse on illegal accesses.
//
// Request semantics: wr_en_i / rd_en_i are requests sampled on the rising
// edge. A write is accepted only when full_o is low and a read only when
// empty_o is low, judged on the flags present before that edge. There is
// no other handshake. A rejected request changes nothing except error_o.
module async_fifo #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             error_o
);

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [PTR_WIDTH:0]   r_wr_ptr;
  logic [PTR_WIDTH:0]   r_rd_ptr;
  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [WIDTH-1:0]     r_rdata;
  logic                 r_error;

  logic                 w_wr_req;
  logic                 w_rd_req;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_acc;
  logic                 w_rd_acc;

  // An X or undriven enable must not count as a request.
  assign w_wr_req = (wr_en_i === 1'b1);
  assign w_rd_req = (rd_en_i === 1'b1);

  // Status decoded from the registered pointers.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_WIDTH] != r_rd_ptr[PTR_WIDTH]) &&
                   (r_wr_ptr[PTR_WIDTH-1:0] == r_rd_ptr[PTR_WIDTH-1:0]);

  assign w_wr_acc = w_wr_req && !w_full;
  assign w_rd_acc = w_rd_req && !w_empty;

  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign rdata_o = r_rdata;
  assign error_o = r_error;

  // Storage array: written on accepted writes, never cleared by reset.
  always_ff @(posedge clk_i) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[PTR_WIDTH-1:0]] <= wdata_i;
    end
  end

  // Write pointer advances on each accepted write, wrapping modulo 2*DEPTH.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
    end else if (w_wr_acc) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Read pointer and registered read data; data holds when no read is accepted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_ptr <= '0;
      r_rdata  <= '0;
    end else if (w_rd_acc) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
      r_rdata  <= r_mem[r_rd_ptr[PTR_WIDTH-1:0]];
    end
  end

  // One-cycle pulse for every edge that saw an illegal request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_error <= 1'b0;
    end else begin
      r_error <= (w_wr_req && w_full) || (w_rd_req && w_empty);
    end
  end

endmodule

// File: tb/tb_async_fifo.sv
// Bench for async_fifo: directed vector table, fill/drain/overflow/underflow
// sequences, randomized concurrent traffic against a queue model, and an
// asynchronous reset in the middle of operation.
module tb_async_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk_i;
  logic             rst_n_i;
  logic             wr_en_i;
  logic [WIDTH-1:0] wdata_i;
  logic             full_o;
  logic             rd_en_i;
  logic [WIDTH-1:0] rdata_o;
  logic             empty_o;
  logic             error_o;

  async_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PTR_WIDTH(4)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .wr_en_i (wr_en_i),
    .wdata_i (wdata_i),
    .full_o  (full_o),
    .rd_en_i (rd_en_i),
    .rdata_o (rdata_o),
    .empty_o (empty_o),
    .error_o (error_o)
  );

  // Clock / reset block
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Scoreboard state: contents held by the FIFO in write order, and the
  // value rdata_o must show.
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_rdata;
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic             wr;
    logic [WIDTH-1:0] wd;
    logic             rd;
    logic             e_full;
    logic             e_empty;
    logic             e_err;
    logic [WIDTH-1:0] e_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: apply one cycle of requests at the negedge, update the model,
  // then sample the outputs at the next negedge.
  task automatic step(input logic wr, input logic [WIDTH-1:0] wd, input logic rd);
    logic was_full, was_empty, e_err;
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    wr_en_i = wr;
    wdata_i = wd;
    rd_en_i = rd;
    e_err = (wr && was_full) || (rd && was_empty);
    if (rd && !was_empty) exp_rdata = exp_q.pop_front();
    if (wr && !was_full) exp_q.push_back(wd);
    @(posedge clk_i);
    @(negedge clk_i);
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    chk("rdata", 32'(rdata_o), 32'(exp_rdata));
    chk("error", 32'(error_o), 32'(e_err));
    chk("full",  32'(full_o),  32'(exp_q.size() == DEPTH));
    chk("empty", 32'(empty_o), 32'(exp_q.size() == 0));
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    wdata_i = '0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    exp_q.delete();
    exp_rdata = '0;
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full",  32'(full_o),  32'd0);
    chk("rst_rdata", 32'(rdata_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) step(1'b1, WIDTH'($urandom), 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [WIDTH-1:0] last_word;
    int wr_left, rd_left, wr_gap, rd_gap, budget;
    logic w, r;

    // Directed vectors starting from an empty FIFO.
    vecs[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00}; // read when empty
    vecs[1] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}; // first write
    vecs[2] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11}; // both, occupancy unchanged
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22}; // read last word
    vecs[4] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22}; // both when empty: write wins
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22}; // idle, pulse ends
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].wr, vecs[i].wd, vecs[i].rd);
      chk("vec_rdata", 32'(rdata_o), 32'(vecs[i].e_rdata));
      chk("vec_error", 32'(error_o), 32'(vecs[i].e_err));
      chk("vec_full",  32'(full_o),  32'(vecs[i].e_full));
      chk("vec_empty", 32'(empty_o), 32'(vecs[i].e_empty));
    end

    // Fill then drain.
    do_reset();
    step(1'b1, WIDTH'($urandom), 1'b0);
    chk("fill_empty_falls", 32'(empty_o), 32'd0);
    fill(15);
    chk("fill_full", 32'(full_o), 32'd1);
    // Both requested while full: read accepted, write rejected.
    step(1'b1, 8'hEE, 1'b1);
    chk("full_both_err", 32'(error_o), 32'd1);
    fill(1);
    drain(16);
    chk("drain_empty", 32'(empty_o), 32'd1);

    // Overflow: 17 writes, then a drain that yields only the first 16.
    do_reset();
    fill(16);
    step(1'b1, 8'hC3, 1'b0);
    chk("ovf_err",  32'(error_o), 32'd1);
    chk("ovf_full", 32'(full_o),  32'd1);
    step(1'b0, '0, 1'b0);
    chk("ovf_err_pulse", 32'(error_o), 32'd0);
    drain(16);

    // Underflow: 16 writes, 17 reads; rdata keeps the 16th word.
    do_reset();
    fill(16);
    last_word = exp_q[DEPTH-1];
    drain(16);
    step(1'b0, '0, 1'b1);
    chk("unf_err",   32'(error_o), 32'd1);
    chk("unf_rdata", 32'(rdata_o), 32'(last_word));
    chk("unf_empty", 32'(empty_o), 32'd1);
    step(1'b0, '0, 1'b0);
    chk("unf_err_pulse", 32'(error_o), 32'd0);

    // Concurrent randomized traffic: 500 write and 501 read attempts with gaps.
    do_reset();
    wr_left = 500;
    rd_left = 501;
    wr_gap  = 0;
    rd_gap  = $urandom_range(1, 4);
    budget  = 20000;
    while ((wr_left > 0 || rd_left > 0) && budget > 0) begin
      w = (wr_left > 0) && (wr_gap == 0);
      r = (rd_left > 0) && (rd_gap == 0);
      if (w) begin wr_left--; wr_gap = $urandom_range(1, 13); end
      else if (wr_gap > 0) wr_gap--;
      if (r) begin rd_left--; rd_gap = $urandom_range(1, 12); end
      else if (rd_gap > 0) rd_gap--;
      step(w, WIDTH'($urandom), r);
      budget--;
    end
    chk("conc_budget", 32'(budget > 0), 32'd1);

    // Reset asserted between clock edges in the middle of operation.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'h51 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    chk("mid_rdata_before", 32'(rdata_o), 32'h51);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(empty_o), 32'd1);
    chk("mid_rst_full",  32'(full_o),  32'd0);
    chk("mid_rst_rdata", 32'(rdata_o), 32'd0);
    chk("mid_rst_error", 32'(error_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    exp_q.delete();
    exp_rdata = '0;
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("mid_a5", 32'(rdata_o), 32'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
